// File: rtl/dev_bus_master_pkg.sv
// Shared definitions for the device bus master: FSM states, access-size
// encodings, the uncached address segment and the alignment rule.
package dev_bus_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [2:0] UNCACHED_SEG = 3'b101;

  // Size code 3 is undefined and is reported as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dev_bus_lane.sv
// Byte-lane logic for the device bus master (purely combinational):
// write strobe / lane replication for requests and lane select plus
// sign/zero extension for read responses.
module dev_bus_lane
  import dev_bus_master_pkg::*;
(
  input  logic [1:0]  i_enc_off,
  input  logic [1:0]  i_enc_size,
  input  logic [31:0] i_enc_wdata,
  output logic [3:0]  o_strb,
  output logic [31:0] o_wdata,
  input  logic [1:0]  i_ext_off,
  input  logic [1:0]  i_ext_size,
  input  logic        i_ext_signed,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  logic [15:0] w_lane;

  assign w_lane = 16'(i_rdata >> {i_ext_off, 3'b000});

  // Request encode: strobe follows the addressed lanes, data is replicated.
  always_comb begin
    o_strb  = 4'b1111;
    o_wdata = i_enc_wdata;
    case (i_enc_size)
      SZ_BYTE: begin
        o_strb  = 4'b0001 << i_enc_off;
        o_wdata = {4{i_enc_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_strb  = 4'b0011 << i_enc_off;
        o_wdata = {2{i_enc_wdata[15:0]}};
      end
      default: begin
        o_strb  = 4'b1111;
        o_wdata = i_enc_wdata;
      end
    endcase
  end

  // Response extract: pick the addressed lane, then extend to 32 bits.
  always_comb begin
    o_rdata = i_rdata;
    case (i_ext_size)
      SZ_BYTE: o_rdata = {{24{i_ext_signed & w_lane[7]}}, w_lane[7:0]};
      SZ_HALF: o_rdata = {{16{i_ext_signed & w_lane[15]}}, w_lane};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/dev_bus_master.sv
// Device bus master: turns single CPU load/store ops into one device
// request/response pair (IDLE -> REQ -> RESP -> DONE).
// Optional feature: define BUS_TIMEOUT_EN to bound the RESP wait to
// TIMEOUT_CYCLES cycles; without it RESP waits indefinitely.
module dev_bus_master
  import dev_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_wen,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_signed,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_err,
  output logic        out_req_valid,
  input  logic        out_req_ready,
  output logic        out_req_bits_is_cached,
  output logic [31:0] out_req_bits_addr,
  output logic [1:0]  out_req_bits_len,
  output logic [31:0] out_req_bits_data,
  output logic        out_req_bits_func,
  output logic [3:0]  out_req_bits_strb,
  output logic        out_resp_ready,
  input  logic        out_resp_valid,
  input  logic [31:0] out_resp_bits_data
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_mis;
  logic        w_req_fire;
  logic        w_resp_fire;
  logic        w_timeout;
  logic [31:0] r_addr;
  logic [1:0]  r_len;
  logic        r_func;
  logic        r_cached;
  logic        r_signed;
  logic [3:0]  r_strb;
  logic [31:0] r_data;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [3:0]  w_enc_strb;
  logic [31:0] w_enc_data;
  logic [31:0] w_ext_data;

  assign w_mis       = is_misaligned(cpu_addr[1:0], cpu_size);
  assign w_req_fire  = (r_state == REQ) && out_req_ready;
  assign w_resp_fire = (r_state == RESP) && out_resp_valid;

  assign out_req_bits_addr      = r_addr;
  assign out_req_bits_len       = r_len;
  assign out_req_bits_func      = r_func;
  assign out_req_bits_is_cached = r_cached;
  assign out_req_bits_strb      = r_strb;
  assign out_req_bits_data      = r_data;
  assign cpu_rdata              = r_rdata;
  assign cpu_err                = r_err;

  dev_bus_lane u_lane (
    .i_enc_off    (cpu_addr[1:0]),
    .i_enc_size   (cpu_size),
    .i_enc_wdata  (cpu_wdata),
    .o_strb       (w_enc_strb),
    .o_wdata      (w_enc_data),
    .i_ext_off    (r_addr[1:0]),
    .i_ext_size   (r_len),
    .i_ext_signed (r_signed),
    .i_rdata      (out_resp_bits_data),
    .o_rdata      (w_ext_data)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Response-wait counter: cleared on RESP entry, counts every RESP cycle.
  always_ff @(posedge clock) begin
    if (!reset)               r_tmo_cnt <= '0;
    else if (w_req_fire)      r_tmo_cnt <= '0;
    else if (r_state == RESP) r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and handshake outputs; handshakes held low in reset.
  always_comb begin
    w_next         = r_state;
    w_timeout      = 1'b0;
    cpu_ready      = 1'b0;
    cpu_done       = 1'b0;
    out_req_valid  = 1'b0;
    out_resp_ready = 1'b0;
    w_accept       = 1'b0;
    case (r_state)
      IDLE: begin
        cpu_ready      = reset;
        out_resp_ready = reset;
        w_accept       = cpu_valid && reset;
        if (w_accept) w_next = w_mis ? DONE : REQ;
      end
      REQ: begin
        out_req_valid = 1'b1;
        if (out_req_ready) w_next = RESP;
      end
      RESP: begin
        out_resp_ready = reset;
        if (out_resp_valid) begin
          w_next = DONE;
        end
`ifdef BUS_TIMEOUT_EN
        else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          w_next    = DONE;
          w_timeout = 1'b1;
        end
`endif
      end
      DONE: begin
        cpu_done = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request field latch on accept; result capture on response or timeout.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_addr   <= '0;
      r_len    <= '0;
      r_func   <= 1'b0;
      r_cached <= 1'b0;
      r_signed <= 1'b0;
      r_strb   <= '0;
      r_data   <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_err   <= w_mis;
        r_rdata <= '0;
        if (!w_mis) begin
          r_addr   <= cpu_addr;
          r_len    <= cpu_size;
          r_func   <= cpu_wen;
          r_cached <= (cpu_addr[31:29] != UNCACHED_SEG);
          r_signed <= cpu_signed;
          r_strb   <= w_enc_strb;
          r_data   <= w_enc_data;
        end
      end
      if (w_resp_fire) begin
        r_rdata <= r_func ? 32'd0 : w_ext_data;
        r_err   <= 1'b0;
      end
      if (w_timeout) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b1;
      end
    end
  end

endmodule
